reg_file_reader: RTL and testbench

REG_FILE_READER -- requirements
Module: reg_file_reader

---
 rtl/regfile_pkg.sv | 15 +
 rtl/reg_file_reader.sv | 105 ++++++++++
 tb/tb_reg_file_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the register-file dump reader.
package regfile_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CSUM,
    DONE
  } reader_state_t;

endpackage

// File: rtl/reg_file_reader.sv
// Streams registers first_addr..last_addr (wrapping) out of a register file read port.
// Define REGDUMP_CHECKSUM_EN to append a checksum beat after the last register.
module reg_file_reader
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] RA,
  input  logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  reader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Read port is only addressed during FETCH so RD is sampled exactly then.
  assign RA        = (state == FETCH) ? addr : '0;
  assign out_valid = (state == SEND) || (state == CSUM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      last     <= '0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= first_addr;
            last  <= last_addr;
`ifdef REGDUMP_CHECKSUM_EN
            csum  <= '0;
`endif
            state <= FETCH;
          end
        end
        FETCH: begin
          out_data <= RD;
          out_addr <= addr;
`ifdef REGDUMP_CHECKSUM_EN
          csum     <= csum + RD;
          out_last <= 1'b0;
`else
          out_last <= (addr == last);
`endif
          state    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (addr == last) begin
`ifdef REGDUMP_CHECKSUM_EN
              // csum already includes the word just accepted
              out_data <= csum;
              out_addr <= '1;
              out_last <= 1'b1;
              state    <= CSUM;
`else
              out_last <= 1'b0;
              state    <= DONE;
`endif
            end else begin
              addr  <= addr + 1'b1;
              state <= FETCH;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_last <= 1'b0;
            state    <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader; expected beats queued at issue, checked by a monitor.
module tb_reg_file_reader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] RA;
  logic [DW-1:0] RD;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [16];

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;

  always #5 clk = ~clk;
  assign RD = regs[RA];

  reg_file_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .RA        (RA),
    .RD        (RD),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expected beat per handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {28'd0, out_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_addr", {28'd0, out_addr}, {28'd0, mon_e.a});
        check("beat_data", {24'd0, out_data}, {24'd0, mon_e.d});
        check("beat_last", {31'd0, out_last}, {31'd0, mon_e.l});
        check("beat_RA_idle", {28'd0, RA}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_scan(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] a;
    logic [7:0] sum;
    a   = f;
    sum = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      exp_q.push_back('{a: a, d: regs[a], l: (CS == 0) && (a == l)});
      sum = sum + regs[a];
      if (a == l) break;
      a = a + 4'd1;
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back('{a: 4'hF, d: sum, l: 1'b1});
`endif
  endtask

  task automatic launch(input logic [3:0] f, input logic [3:0] l, input bit push);
    if (push) push_scan(f, l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Waits for done (bounded), then checks the scan wrapped up cleanly.
  task automatic finish(input string name, input int d0, input int exp_cycles, input int cyc0);
    int cycles;
    cycles = cyc0;
    while (done !== 1'b1 && cycles < 300) begin
      step();
      cycles++;
    end
    if (done !== 1'b1) check({name, "_done_timeout"}, 32'd0, 32'd1);
    if (exp_cycles > 0) check({name, "_latency"}, cycles, exp_cycles);
    step();
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({name, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);

    // Reset state
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_addr", {28'd0, out_addr}, 32'd0);
    check("rst_RA", {28'd0, RA}, 32'd0);
    rst_n = 1'b1;
    step();

    // 2..4 at full throughput: 3 beats, two cycles per beat
    d0 = done_cnt;
    launch(4'd2, 4'd4, 1'b1);
    check("fetch_RA", {28'd0, RA}, 32'd2);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    finish("scan_2_4", d0, 7 + CS, 1);

    // Wrap-around 14..1 with r0 = 0x00
    regs[0] = 8'h00;
    d0 = done_cnt;
    launch(4'd14, 4'd1, 1'b1);
    finish("scan_wrap", d0, 9 + CS, 1);

    // Single word
    d0 = done_cnt;
    launch(4'd7, 4'd7, 1'b1);
    finish("scan_single", d0, 3 + CS, 1);

    // Backpressure on the first beat
    d0 = done_cnt;
    out_ready = 1'b0;
    launch(4'd5, 4'd6, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_addr", {28'd0, out_addr}, 32'd5);
      check("stall_data", {24'd0, out_data}, 32'h15);
      check("stall_RA", {28'd0, RA}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    finish("scan_stall", d0, 0, 0);

    // start pulsed mid-scan must be ignored
    d0 = done_cnt;
    launch(4'd3, 4'd5, 1'b1);
    step();
    step();
    first_addr = 4'd9;
    last_addr  = 4'd9;
    start      = 1'b1;
    step();
    start      = 1'b0;
    finish("scan_busy_start", d0, 0, 0);
    repeat (3) step();
    check("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Checksum scenario values (plain scan when checksum is not built)
    regs[1] = 8'hF0;
    regs[2] = 8'h20;
    d0 = done_cnt;
    launch(4'd1, 4'd2, 1'b1);
    finish("scan_csum", d0, 5 + CS, 1);

    // Reset during the second beat of 2..9
    d0 = done_cnt;
    exp_q.push_back('{a: 4'd2, d: regs[2], l: 1'b0});
    launch(4'd2, 4'd9, 1'b0);
    n = 0;
    while (!(out_valid === 1'b1 && out_addr == 4'd3) && n < 20) begin
      step();
      n++;
    end
    check("abort_second_beat_seen", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_data", {24'd0, out_data}, 32'd0);
    check("abort_RA", {28'd0, RA}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
